// File: rtl/mul_share_sched.sv
// Round-robin front end sharing one pipelined unsigned multiplier among NUM_REQ requesters.
// Tracks owner tags alongside the multiplier pipeline and stalls the pipe on response backpressure.
module mul_share_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DIN_WIDTH   = 50,
    parameter int DOUT_WIDTH  = 100,
    parameter int MUL_LATENCY = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]     req_din0,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]     req_din1,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DOUT_WIDTH-1:0]            rsp_data,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic                             mul_ce,
    output logic [DIN_WIDTH-1:0]             mul_din0,
    output logic [DIN_WIDTH-1:0]             mul_din1,
    input  logic [DOUT_WIDTH-1:0]            mul_dout,
    output logic [$clog2(MUL_LATENCY+1)-1:0] inflight
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int INF_W = $clog2(MUL_LATENCY+1);
    localparam int LAST  = MUL_LATENCY - 1;

    logic [MUL_LATENCY-1:0] vld;
    logic [PTR_W-1:0]       tag [MUL_LATENCY];
    logic [PTR_W-1:0]       rr_ptr;
    logic [DIN_WIDTH-1:0]   din0_q;
    logic [DIN_WIDTH-1:0]   din1_q;

    logic [DIN_WIDTH-1:0]   din0_arr [NUM_REQ];
    logic [DIN_WIDTH-1:0]   din1_arr [NUM_REQ];

    logic                   stall;
    logic                   grant_any;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       cand_idx;
    int                     cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign din0_arr[g] = req_din0[g*DIN_WIDTH +: DIN_WIDTH];
        assign din1_arr[g] = req_din1[g*DIN_WIDTH +: DIN_WIDTH];
    end

    // An unaccepted product at the tail freezes the whole pipe, multiplier included.
    assign stall  = vld[LAST] & ~rsp_ready[tag[LAST]];
    assign mul_ce = ~stall;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!stall && !grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operands follow the winner; idle cycles replay the last issued pair to avoid toggling.
    assign mul_din0 = grant_any ? din0_arr[grant_idx] : din0_q;
    assign mul_din1 = grant_any ? din1_arr[grant_idx] : din1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= PTR_W'(NUM_REQ - 1);
            din0_q <= '0;
            din1_q <= '0;
        end else if (grant_any) begin
            rr_ptr <= grant_idx;
            din0_q <= din0_arr[grant_idx];
            din1_q <= din1_arr[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag[i] <= '0;
            end
        end else if (mul_ce) begin
            vld[0] <= grant_any;
            tag[0] <= grant_idx;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            inflight = inflight + INF_W'(vld[i]);
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = vld[LAST] && (tag[LAST] == PTR_W'(i));
        end
    end

    assign rsp_data = mul_dout;

    a_grant_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ready));
    a_rsp_onehot   : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsp_valid));
    a_no_grant_stall : assert property (@(posedge clk) disable iff (!reset_n) stall |-> (req_ready == '0));

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with a behavioural ce-gated 4-stage multiplier.
module tb_mul_share_sched;

    localparam int NR  = 4;
    localparam int DW  = 50;
    localparam int OW  = 100;
    localparam int LAT = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NR-1:0]        req_valid;
    logic [NR*DW-1:0]     req_din0;
    logic [NR*DW-1:0]     req_din1;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [OW-1:0]        rsp_data;
    logic [NR-1:0]        rsp_ready;
    logic                 mul_ce;
    logic [DW-1:0]        mul_din0;
    logic [DW-1:0]        mul_din1;
    logic [OW-1:0]        mul_dout;
    logic [2:0]           inflight;

    logic [DW-1:0]        op_a [NR];
    logic [DW-1:0]        op_b [NR];
    logic [OW-1:0]        mpipe [LAT];

    always #5 clk = ~clk;

    assign req_din0 = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_din1 = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= OW'(mul_din0) * OW'(mul_din1);
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_dout = mpipe[LAT-1];

    mul_share_sched #(
        .NUM_REQ(NR), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MUL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_din0(req_din0), .req_din1(req_din1), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .inflight(inflight)
    );

    typedef struct {
        logic [1:0]    r;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] p;
    } vec_t;

    vec_t vecs [6];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [NR-1:0] oh;
    logic [OW-1:0] fexp  [4];
    logic [OW-1:0] bpexp [3];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{r: 2'd0, a: 50'd3, b: 50'd5, p: 100'd15};
        vecs[1] = '{r: 2'd2, a: 50'h3FFFFFFFFFFFF, b: 50'h3FFFFFFFFFFFF, p: 100'hFFFFFFFFFFFF8000000000001};
        vecs[2] = '{r: 2'd1, a: 50'd12345, b: 50'd67890, p: 100'd838102050};
        vecs[3] = '{r: 2'd3, a: 50'h2000000000000, b: 50'd4, p: 100'h8000000000000};
        vecs[4] = '{r: 2'd0, a: 50'd0, b: 50'h3FFFFFFFFFFFF, p: 100'd0};
        vecs[5] = '{r: 2'd3, a: 50'h3FFFFFFFFFFFF, b: 50'd1, p: 100'h3FFFFFFFFFFFF};
        fexp  = '{100'd6, 100'd12, 100'd20, 100'd30};
        bpexp = '{100'd6, 100'd20, 100'd42};

        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset state
        #12;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_mul_ce",    128'(mul_ce),    128'(1));
        chk("rst_inflight",  128'(inflight),  128'(0));
        chk("rst_mul_din0",  128'(mul_din0),  128'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Fairness: all requesters active from reset
        for (int i = 0; i < NR; i++) begin
            op_a[i] = DW'(i + 2);
            op_b[i] = DW'(i + 3);
        end
        for (int k = 0; k < 12; k++) begin
            cyc();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #2;
            if (k < 8) chk("fair_grant", 128'(req_ready), 128'(4'b0001 << (k % 4)));
            else       chk("fair_nogrant", 128'(req_ready), 128'(0));
            if (k >= 4) begin
                chk("fair_rsp_valid", 128'(rsp_valid), 128'(4'b0001 << ((k - 4) % 4)));
                chk("fair_rsp_data",  128'(rsp_data),  128'(fexp[(k - 4) % 4]));
            end else begin
                chk("fair_rsp_idle", 128'(rsp_valid), 128'(0));
            end
        end
        cyc();
        #2 chk("fair_drain", 128'(inflight), 128'(0));

        // Table of single operations
        for (int v = 0; v < 6; v++) begin
            oh = 4'b0001 << vecs[v].r;
            cyc();
            op_a[vecs[v].r] = vecs[v].a;
            op_b[vecs[v].r] = vecs[v].b;
            req_valid = oh;
            #2;
            chk("vec_grant",    128'(req_ready), 128'(oh));
            chk("vec_mul_din0", 128'(mul_din0),  128'(vecs[v].a));
            cyc();
            req_valid = '0;
            #2;
            chk("vec_inflight1", 128'(inflight), 128'(1));
            chk("vec_hold_din1", 128'(mul_din1), 128'(vecs[v].b));
            chk("vec_early_rsp", 128'(rsp_valid), 128'(0));
            cyc();
            cyc();
            cyc();
            #2;
            chk("vec_rsp_valid", 128'(rsp_valid), 128'(oh));
            chk("vec_rsp_data",  128'(rsp_data),  128'(vecs[v].p));
            chk("vec_inflight4", 128'(inflight),  128'(1));
            cyc();
            #2;
            chk("vec_rsp_done",  128'(rsp_valid), 128'(0));
            chk("vec_inflight0", 128'(inflight),  128'(0));
        end

        // Backpressure on requester 1
        op_b[1] = 50'd3;
        for (int k = 0; k < 13; k++) begin
            cyc();
            req_valid[1] = (k < 3);
            if (k < 3) begin
                op_a[1] = DW'(2 * k + 2);
                op_b[1] = DW'(2 * k + 3);
            end
            req_valid[0] = (k >= 4 && k <= 8);
            rsp_ready[1] = !(k >= 4 && k <= 8);
            #2;
            if (k < 3) chk("bp_grant", 128'(req_ready), 128'(4'b0010));
            if (k == 3) chk("bp_pre_rsp", 128'(rsp_valid), 128'(0));
            if (k >= 4 && k <= 8) begin
                chk("bp_mul_ce",    128'(mul_ce),    128'(0));
                chk("bp_req_ready", 128'(req_ready), 128'(0));
                chk("bp_rsp_valid", 128'(rsp_valid), 128'(4'b0010));
                chk("bp_rsp_data",  128'(rsp_data),  128'(6));
                chk("bp_inflight",  128'(inflight),  128'(3));
            end
            if (k >= 9 && k <= 11) begin
                chk("bp_drain_ce",    128'(mul_ce),    128'(1));
                chk("bp_drain_valid", 128'(rsp_valid), 128'(4'b0010));
                chk("bp_drain_data",  128'(rsp_data),  128'(bpexp[k - 9]));
            end
            if (k == 12) begin
                chk("bp_end_valid",    128'(rsp_valid), 128'(0));
                chk("bp_end_inflight", 128'(inflight),  128'(0));
            end
        end
        req_valid = '0;
        rsp_ready = '1;

        // Reset with two operations in flight
        op_a[2] = 50'd11; op_b[2] = 50'd13;
        op_a[1] = 50'd17; op_b[1] = 50'd19;
        cyc();
        req_valid = 4'b0100;
        #2 chk("rst_mid_grant2", 128'(req_ready), 128'(4'b0100));
        cyc();
        req_valid = 4'b0010;
        #2 chk("rst_mid_grant1", 128'(req_ready), 128'(4'b0010));
        cyc();
        req_valid = '0;
        reset_n = 1'b0;
        #2;
        chk("rst_mid_inflight", 128'(inflight),  128'(0));
        chk("rst_mid_rsp",      128'(rsp_valid), 128'(0));
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            #2;
            chk("rst_mid_no_rsp",   128'(rsp_valid), 128'(0));
            chk("rst_mid_inflight0", 128'(inflight), 128'(0));
        end
        op_a[0] = 50'd9; op_b[0] = 50'd9;
        cyc();
        req_valid = 4'hF;
        #2 chk("rst_mid_first_grant", 128'(req_ready), 128'(4'b0001));
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        cyc();
        #2;
        chk("rst_mid_post_valid", 128'(rsp_valid), 128'(4'b0001));
        chk("rst_mid_post_data",  128'(rsp_data),  128'(81));
        cyc();

        // Sparse: requester 3 every other cycle
        op_b[3] = 50'd7;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (k < 8 && (k % 2) == 0) begin
                req_valid = 4'b1000;
                op_a[3] = DW'(1000 * (k / 2 + 1));
            end else begin
                req_valid = '0;
            end
            #2;
            chk("sparse_inflight_le2", 128'(inflight <= 3'd2), 128'(1));
            if (k < 8 && (k % 2) == 0) chk("sparse_grant", 128'(req_ready), 128'(4'b1000));
            if (k >= 4 && k <= 10 && (k % 2) == 0) begin
                chk("sparse_rsp_valid", 128'(rsp_valid), 128'(4'b1000));
                chk("sparse_rsp_data",  128'(rsp_data),  128'(7000 * ((k - 4) / 2 + 1)));
            end else begin
                chk("sparse_bubble", 128'(rsp_valid), 128'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
